m_mem_arb: RTL

//  Shares one single-port synchronous unified memory between the IF stage (instruction fetch) and
//  the MEM stage (load/store) of the m_proc5 pipeline. Arbitrates requests, drives the memory port,

---
 rtl/m_mem_arb_if.sv | 50 +++++
 rtl/m_mem_arb.sv | 112 +++++++++++
 2 files changed

// File: rtl/m_mem_arb_if.sv
// Bundle of the IF fetch port, the MEM load/store port, the shared memory port and the contention counter.
// slave = the arbiter side, master = the pipeline/memory side.
interface m_mem_arb_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    // Requests are levels held until the matching one-cycle ack; an ack is never
    // followed by a re-grant in the same cycle, and rdata is zero outside its ack.
    logic            w_if_req;
    logic [AW-1:0]   w_if_addr;
    logic            w_if_ack;
    logic [DW-1:0]   w_if_rdata;

    logic            w_dm_req;
    logic            w_dm_we;
    logic [DW/8-1:0] w_dm_be;
    logic [AW-1:0]   w_dm_addr;
    logic [DW-1:0]   w_dm_wdata;
    logic            w_dm_ack;
    logic [DW-1:0]   w_dm_rdata;

    logic            w_mem_en;
    logic            w_mem_we;
    logic [DW/8-1:0] w_mem_be;
    logic [AW-1:0]   w_mem_addr;
    logic [DW-1:0]   w_mem_wdata;
    logic [DW-1:0]   w_mem_rdata;

    logic [7:0]      w_conf_cnt;

    modport slave (
        input  w_if_req, w_if_addr,
        output w_if_ack, w_if_rdata,
        input  w_dm_req, w_dm_we, w_dm_be, w_dm_addr, w_dm_wdata,
        output w_dm_ack, w_dm_rdata,
        output w_mem_en, w_mem_we, w_mem_be, w_mem_addr, w_mem_wdata,
        input  w_mem_rdata,
        output w_conf_cnt
    );

    modport master (
        output w_if_req, w_if_addr,
        input  w_if_ack, w_if_rdata,
        output w_dm_req, w_dm_we, w_dm_be, w_dm_addr, w_dm_wdata,
        input  w_dm_ack, w_dm_rdata,
        input  w_mem_en, w_mem_we, w_mem_be, w_mem_addr, w_mem_wdata,
        output w_mem_rdata,
        input  w_conf_cnt
    );
endinterface

// File: rtl/m_mem_arb.sv
// Arbiter sharing one single-port synchronous memory between instruction fetch and load/store.
// Optional IF anti-starvation promotion is compiled in with M_ARB_STARVE_GUARD_EN.
module m_mem_arb #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4,
    localparam int SW        = $clog2(STARVE_MAX + 1)
) (
    input  logic          w_clk,
    input  logic          w_rst_n,
    m_mem_arb_if.slave    bus,
    output logic [1:0]    w_pend_dbg,   // 0 none, 1 IF, 2 DM store, 3 DM load
    output logic [SW-1:0] w_starve_dbg
);

    typedef enum logic [1:0] {
        P_NONE  = 2'd0,
        P_IF    = 2'd1,
        P_DM    = 2'd2,
        P_DM_RD = 2'd3
    } pend_e;

    pend_e pend, pend_nxt;
    logic  if_elig, dm_elig;
    logic  gnt_if, gnt_dm;
    logic  promote;
    logic  [7:0] conf_cnt;

    // A requester being acked this cycle still holds req high; it must not be re-granted.
    always_comb begin
        if_elig = w_rst_n & bus.w_if_req & (pend != P_IF);
        dm_elig = w_rst_n & bus.w_dm_req & (pend != P_DM) & (pend != P_DM_RD);
        gnt_dm  = dm_elig & ~promote;
        gnt_if  = if_elig & ~gnt_dm;
    end

`ifdef M_ARB_STARVE_GUARD_EN
    logic [SW-1:0] starve_cnt;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            starve_cnt <= '0;
        end else if (gnt_if) begin
            starve_cnt <= '0;
        end else if (if_elig) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    assign promote      = if_elig & (starve_cnt == SW'(STARVE_MAX));
    assign w_starve_dbg = starve_cnt;
`else
    assign promote      = 1'b0;
    assign w_starve_dbg = '0;
`endif

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            pend <= P_NONE;
        end else begin
            pend <= pend_nxt;
        end
    end

    // Winner drives the memory port this cycle; its ack follows next cycle from pend.
    always_comb begin
        pend_nxt        = P_NONE;
        bus.w_mem_en    = 1'b0;
        bus.w_mem_we    = 1'b0;
        bus.w_mem_be    = '0;
        bus.w_mem_addr  = '0;
        bus.w_mem_wdata = '0;
        if (gnt_dm) begin
            pend_nxt        = bus.w_dm_we ? P_DM : P_DM_RD;
            bus.w_mem_en    = 1'b1;
            bus.w_mem_we    = bus.w_dm_we;
            bus.w_mem_be    = bus.w_dm_be;
            bus.w_mem_addr  = bus.w_dm_addr;
            bus.w_mem_wdata = bus.w_dm_wdata;
        end else if (gnt_if) begin
            pend_nxt        = P_IF;
            bus.w_mem_en    = 1'b1;
            bus.w_mem_addr  = bus.w_if_addr;
        end
    end

    always_comb begin
        bus.w_if_ack   = (pend == P_IF);
        bus.w_if_rdata = '0;
        bus.w_dm_ack   = (pend == P_DM) || (pend == P_DM_RD);
        bus.w_dm_rdata = '0;
        if (pend == P_IF) begin
            bus.w_if_rdata = bus.w_mem_rdata;
        end
        if (pend == P_DM_RD) begin
            bus.w_dm_rdata = bus.w_mem_rdata;
        end
    end

    // Contention: both requesters eligible in the same cycle; saturates instead of wrapping.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            conf_cnt <= 8'd0;
        end else if (if_elig && dm_elig && (conf_cnt != 8'hFF)) begin
            conf_cnt <= conf_cnt + 8'd1;
        end
    end

    assign bus.w_conf_cnt = conf_cnt;
    assign w_pend_dbg     = pend;

endmodule
